// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, read bypass and a per-register busy scoreboard.
// Latency: reads are combinational (zero cycles); writes, sets and clears commit at the next rising clk.
// Backpressure: none; every write, set and read is accepted in the cycle it is presented.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     wclr0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     wclr1,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy
);

  // Register 0 and addresses beyond the array are never stored, never busy and read as zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic wv0, wv1, sv;

  assign wv0 = we0 && in_range(waddr0);
  assign wv1 = we1 && in_range(waddr1);
  assign sv  = set_en && in_range(set_addr);

  // Data array: port 1 is the younger producer, so it overrides port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wv1 && (waddr1 == ADDR_W'(i)))      regs[i] <= wdata1;
        else if (wv0 && (waddr0 == ADDR_W'(i))) regs[i] <= wdata0;
      end
    end
  end

  // Scoreboard: a newly issued producer (set) outranks a retiring one (clear) on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (sv && (set_addr == ADDR_W'(i)))
          busy[i] <= 1'b1;
        else if ((wv1 && wclr1 && (waddr1 == ADDR_W'(i))) ||
                 (wv0 && wclr0 && (waddr0 == ADDR_W'(i))))
          busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] arr_val;
    logic              busy_val;
    logic              valid, hit0, hit1;

    assign ra    = raddr[k*ADDR_W +: ADDR_W];
    assign valid = !rst && re[k] && in_range(ra);
    assign hit1  = we1 && (waddr1 == ra);
    assign hit0  = we0 && (waddr0 == ra);

    // Array and scoreboard lookup as an explicit mux so out-of-range addresses never index past the array.
    always_comb begin
      arr_val  = '0;
      busy_val = 1'b0;
      for (int j = 1; j < NUM_REGS; j++) begin
        if (ra == ADDR_W'(j)) begin
          arr_val  = regs[j];
          busy_val = busy[j];
        end
      end
    end

    // A clearing write this cycle supplies the operand via bypass, so it is no longer reported busy.
    assign rdata[k*DATA_W +: DATA_W] = !valid ? '0 :
                                       hit1   ? wdata1 :
                                       hit0   ? wdata0 : arr_val;
    assign rbusy[k] = valid && busy_val && !(hit1 && wclr1) && !(hit0 && wclr0);
  end

endmodule
